tmp_seq_ctrl: RTL and testbench
===============================

// Module: tmp_seq_ctrl
// PURPOSE
//  Parametrised sequencer for the switched-cap temperature front-end, N_CH sensor channels.
//  Runs precharge -> diode -> settle -> first-order charge-balance conversion with
//  optional comparator chopping, counts comparator ones into a CODE_W-bit code.
//  Adds channel muxing, single-shot/continuous modes and a valid/ready result port.
// PARAMETERS
//  N_CH       2   number of sensor channels (1..8)
//  PRE_CYC    11  precharge length, cycles (>=1)
//  DIODE_CYC  1   small-diode phase length, cycles (>=1)
//  SETTLE_CYC 7   big-diode settle length before counting, cycles (>=1)
//  CONV_LOG2  8   conversion length = 2**CONV_LOG2 cycles (>=2)
//  CODE_W     8   result width (>=1)
//  CHOP       1   1: invert cmp_p1/cmp_p2 at half of conversion; 0: no chop
// PORTS
//  clk       in   1               system clock
//  reset     in   1               synchronous, active-high reset
//  start     in   1               single-shot request, sampled in IDLE only
//  cont      in   1               continuous mode: round-robin over all channels
//  ch_sel    in   $clog2(N_CH)    channel for single-shot (max(1,...) bits)
//  cmp       in   1               comparator decision (pre-synchronised)
//  ready     in   1               result consumer ready
//  ch_en     out  N_CH            one-hot active channel, 0 in IDLE
//  preChrg   out  1               precharge enable
//  PA,PB,PC,PD out 1 each         cap switch controls
//  PI2,PII2  out  1 each          big/small diode current enables
//  src_n,snk out  1 each          charge-balance source/sink toggles
//  cmp_p1,cmp_p2 out 1 each       comparator chop phases (always complementary)
//  busy      out  1               FSM not in IDLE
//  valid     out  1               result available
//  code      out  CODE_W          conversion result
//  code_ch   out  $clog2(N_CH)    channel of code
//  ovf       out  1               sticky: unread result overwritten
// BEHAVIOUR
//  Reset: every output 0 except cmp_p2=1; FSM to IDLE; counters, ones count, chan cleared.
//  All outputs are registered and asserted exactly during the cycles FSM occupies a state.
//  IDLE: start=1 and ch_sel<N_CH -> latch chan=ch_sel, go PRECHARGE next cycle. ch_sel>=N_CH:
//   request ignored. cont=1 -> chan=0, go PRECHARGE. start ignored when busy.
//  PRECHARGE (PRE_CYC cyc): preChrg=PB=PC=PD=1.
//  DIODE (DIODE_CYC cyc): PII2=1.
//  SETTLE (SETTLE_CYC cyc): PI2=1; each cycle cmp=1 toggles src_n, cmp=0 toggles snk; no count.
//  CONVERT (2**CONV_LOG2 cyc): as SETTLE plus ones += cmp. CHOP=1: cmp_p1/cmp_p2 invert
//   entering cycle 2**(CONV_LOG2-1), restore to reset polarity on leaving CONVERT.
//  OUTPUT (1 cyc): PA=1; code=min(ones, 2**CODE_W-1) (ones may reach 2**CONV_LOG2);
//   code_ch=chan; valid=1. Next: cont=1 -> chan=(chan+1)%N_CH, PRECHARGE; else IDLE.
//  ch_en[chan]=1 from PRECHARGE through OUTPUT. cont drop mid-run: run completes, then IDLE.
//  Latency single-shot: start to valid = 1+PRE_CYC+DIODE_CYC+SETTLE_CYC+2**CONV_LOG2+1 cycles.
//  Result port: valid held until valid&&ready (clears next cycle). New result while valid&&!ready:
//   overwrite code/code_ch, valid stays 1, ovf=1 (cleared only by reset). New result same cycle
//   as accept: load new, valid stays 1, ovf unchanged.
//  Reset mid-operation: abort at that edge, pending result discarded, valid=0, ovf=0.
// TESTING
//  Defaults, start ch_sel=1, cmp=0 -> preChrg high 11 cyc, PII2 1 cyc, ch_en=2'b10, code=0,
//   snk toggles 263 times, valid at cycle 1+11+1+7+256+1=277.
//  cmp=1 throughout -> ones=256, code saturates 255, src_n toggles 263 times, snk static.
//  cmp alternating 1/0 from CONVERT entry -> code=128; CHOP=1: cmp_p1 flips at conv cycle 128.
//  cont=1, ready=1 -> results code_ch 0,1,0; no IDLE between runs; cont=0 mid-run -> IDLE after.
//  ready=0 over two results -> second overwrites, ovf=1, valid stays 1; ready=1 clears valid.
//  reset asserted mid-CONVERT -> next cycle all outputs reset values, start then gives full run.

Source files
------------

// File: rtl/tmp_seq_ctrl_if.sv
// tmp_seq_ctrl_if
//   Request and result bus of the temperature front-end sequencer.
//   Request side : start, cont, ch_sel (single-shot channel), ready (result consumer).
//   Result side  : valid, code, code_ch, ovf (sticky overwrite flag).
//   slave  : sequencer view (drives the result side).
//   master : host / testbench view (drives the request side).
interface tmp_seq_ctrl_if #(
    parameter int N_CH   = 2,
    parameter int CODE_W = 8
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              start;
    logic              cont;
    logic [CH_W-1:0]   ch_sel;
    logic              ready;
    logic              valid;
    logic [CODE_W-1:0] code;
    logic [CH_W-1:0]   code_ch;
    logic              ovf;

    modport slave (
        input  start, cont, ch_sel, ready,
        output valid, code, code_ch, ovf
    );

    modport master (
        output start, cont, ch_sel, ready,
        input  valid, code, code_ch, ovf
    );
endinterface

// File: rtl/tmp_seq_ctrl.sv
// tmp_seq_ctrl
//   Sequencer for the switched-cap temperature front-end with N_CH channels.
//   Each run: PRECHARGE -> DIODE -> SETTLE -> CONVERT (first-order charge balance,
//   comparator ones counted) -> OUTPUT (result presented on the valid/ready port).
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : start/cont/ch_sel/ready in, valid/code/code_ch/ovf out
//   cmp                 : pre-synchronised comparator decision
//   ch_en               : one-hot active channel, 0 while idle
//   preChrg, PA..PD     : precharge and cap switch controls
//   PI2, PII2           : big / small diode current enables
//   src_n, snk          : charge-balance toggles
//   cmp_p1, cmp_p2      : complementary comparator chop phases
//   busy                : sequencer not idle
module tmp_seq_ctrl #(
    parameter int N_CH       = 2,
    parameter int PRE_CYC    = 11,
    parameter int DIODE_CYC  = 1,
    parameter int SETTLE_CYC = 7,
    parameter int CONV_LOG2  = 8,
    parameter int CODE_W     = 8,
    parameter int CHOP       = 1
) (
    input  logic                clk,
    input  logic                reset,
    tmp_seq_ctrl_if.slave       bus,
    input  logic                cmp,
    output logic [N_CH-1:0]     ch_en,
    output logic                preChrg,
    output logic                PA,
    output logic                PB,
    output logic                PC,
    output logic                PD,
    output logic                PI2,
    output logic                PII2,
    output logic                src_n,
    output logic                snk,
    output logic                cmp_p1,
    output logic                cmp_p2,
    output logic                busy
);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CONV_LEN = 2 ** CONV_LOG2;
    localparam int MAX_A    = (PRE_CYC > DIODE_CYC) ? PRE_CYC : DIODE_CYC;
    localparam int MAX_B    = (SETTLE_CYC > CONV_LEN) ? SETTLE_CYC : CONV_LEN;
    localparam int MAX_LEN  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_LEN + 1);
    localparam int ONES_W   = CONV_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_DIODE, S_SETTLE, S_CONV, S_OUT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CH_W-1:0]   chan, chan_nxt;
    logic [ONES_W-1:0] ones, ones_sum;
    logic              chop_nxt;
    logic              load;

    // A full conversion of ones can reach 2**CONV_LOG2, one more than fits CODE_W
    // when CODE_W == CONV_LOG2, so clamp to the all-ones code.
    function automatic logic [CODE_W-1:0] sat_code(input logic [ONES_W-1:0] v);
        if ((v >> CODE_W) != '0)
            return '1;
        return CODE_W'(v);
    endfunction

    assign ones_sum = ones + ONES_W'(cmp);
    assign load     = (state_nxt == S_OUT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        chan_nxt  = chan;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (bus.cont) begin
                    chan_nxt  = '0;
                    state_nxt = S_PRE;
                end else if (bus.start && (32'(bus.ch_sel) < N_CH)) begin
                    chan_nxt  = bus.ch_sel;
                    state_nxt = S_PRE;
                end
            end
            S_PRE: if (cnt == CNT_W'(PRE_CYC - 1)) begin
                cnt_nxt   = '0;
                state_nxt = S_DIODE;
            end
            S_DIODE: if (cnt == CNT_W'(DIODE_CYC - 1)) begin
                cnt_nxt   = '0;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                cnt_nxt   = '0;
                state_nxt = S_CONV;
            end
            S_CONV: if (cnt == CNT_W'(CONV_LEN - 1)) begin
                cnt_nxt   = '0;
                state_nxt = S_OUT;
            end
            S_OUT: begin
                cnt_nxt = '0;
                if (bus.cont) begin
                    chan_nxt  = (chan == CH_W'(N_CH - 1)) ? '0 : chan + 1'b1;
                    state_nxt = S_PRE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
        // Chop phase flips for the second half of the conversion window.
        chop_nxt = (CHOP != 0) && (state_nxt == S_CONV) && cnt_nxt[CONV_LOG2-1];
    end

    // Outputs are registered from the next state so they line up exactly with
    // the cycles the FSM spends in each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            chan        <= '0;
            ones        <= '0;
            ch_en       <= '0;
            preChrg     <= 1'b0;
            PA          <= 1'b0;
            PB          <= 1'b0;
            PC          <= 1'b0;
            PD          <= 1'b0;
            PI2         <= 1'b0;
            PII2        <= 1'b0;
            src_n       <= 1'b0;
            snk         <= 1'b0;
            cmp_p1      <= 1'b0;
            cmp_p2      <= 1'b1;
            busy        <= 1'b0;
            bus.valid   <= 1'b0;
            bus.code    <= '0;
            bus.code_ch <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            chan    <= chan_nxt;
            ones    <= (state == S_CONV) ? ones_sum : '0;
            busy    <= (state_nxt != S_IDLE);
            ch_en   <= (state_nxt != S_IDLE) ? (N_CH'(1) << chan_nxt) : '0;
            preChrg <= (state_nxt == S_PRE);
            PB      <= (state_nxt == S_PRE);
            PC      <= (state_nxt == S_PRE);
            PD      <= (state_nxt == S_PRE);
            PII2    <= (state_nxt == S_DIODE);
            PI2     <= (state_nxt == S_SETTLE) || (state_nxt == S_CONV);
            PA      <= (state_nxt == S_OUT);
            cmp_p1  <= chop_nxt;
            cmp_p2  <= ~chop_nxt;

            // Charge balance: the comparator decision picks which toggle moves.
            if ((state == S_SETTLE) || (state == S_CONV)) begin
                if (cmp)
                    src_n <= ~src_n;
                else
                    snk <= ~snk;
            end

            // Result port: a new result always loads; overwriting an unread one
            // (valid held, consumer not ready this edge) sets the sticky flag.
            if (load) begin
                bus.code    <= sat_code(ones_sum);
                bus.code_ch <= chan;
                bus.valid   <= 1'b1;
                if (bus.valid && !bus.ready)
                    bus.ovf <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// tb_tmp_seq_ctrl
//   Directed bench for tmp_seq_ctrl with default parameters: table of single-shot
//   runs plus hand-written continuous, overwrite and mid-run reset sequences.
module tb_tmp_seq_ctrl;
    localparam int N_CH   = 2;
    localparam int CODE_W = 8;
    localparam int CH_W   = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmp;
    logic [N_CH-1:0] ch_en;
    logic            preChrg, PA, PB, PC, PD, PI2, PII2;
    logic            src_n, snk, cmp_p1, cmp_p2, busy;

    always #5 clk = ~clk;

    tmp_seq_ctrl_if #(.N_CH(N_CH), .CODE_W(CODE_W)) bus ();

    tmp_seq_ctrl #(
        .N_CH(N_CH), .PRE_CYC(11), .DIODE_CYC(1), .SETTLE_CYC(7),
        .CONV_LOG2(8), .CODE_W(CODE_W), .CHOP(1)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .cmp(cmp),
        .ch_en(ch_en), .preChrg(preChrg), .PA(PA), .PB(PB), .PC(PC), .PD(PD),
        .PI2(PI2), .PII2(PII2), .src_n(src_n), .snk(snk),
        .cmp_p1(cmp_p1), .cmp_p2(cmp_p2), .busy(busy)
    );

    // Every output that must be 0 after reset (cmp_p2 is checked separately).
    wire [24:0] zero_outs = {ch_en, preChrg, PA, PB, PC, PD, PI2, PII2, src_n, snk,
                             cmp_p1, busy, bus.valid, bus.ovf, bus.code, bus.code_ch};

    typedef struct {
        int              pat;      // 0: cmp=0, 1: cmp=1, 2: alternate from CONVERT, 3: 1 in SETTLE only
        logic [CH_W-1:0] ch;
        int              exp_code;
        int              exp_src;
        int              exp_snk;
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Cycle 1 is the start cycle; CONVERT occupies cycles 21..276.
    function automatic logic cmp_for(input int pat, input int k);
        case (pat)
            1:       return 1'b1;
            2:       return (k >= 21) && (((k - 21) % 2) == 0);
            3:       return (k >= 14) && (k <= 20);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_single(input vec_t v, input string tag);
        int              pre_n = 0, dio_n = 0, pi2_n = 0, pa_n = 0;
        int              src_t = 0, snk_t = 0, en_bad = 0, comp_bad = 0;
        int              first_v = 0, first_p1 = 0, code_v = -1, ch_v = -1;
        int              v278 = -1, b278 = -1;
        logic            p_src, p_snk;
        logic [N_CH-1:0] exp_en;
        exp_en        = N_CH'(1) << v.ch;
        bus.ready     = 1'b1;
        bus.cont      = 1'b0;
        tick();
        p_src         = src_n;
        p_snk         = snk;
        bus.start     = 1'b1;
        bus.ch_sel    = v.ch;
        cmp           = cmp_for(v.pat, 1);
        for (int k = 2; k <= 280; k++) begin
            tick();
            bus.start = 1'b0;
            cmp       = cmp_for(v.pat, k);
            if (preChrg) pre_n++;
            if (preChrg && (ch_en != exp_en)) en_bad++;
            if (PII2) dio_n++;
            if (PI2) pi2_n++;
            if (PA) pa_n++;
            if (src_n != p_src) src_t++;
            if (snk != p_snk) snk_t++;
            p_src = src_n;
            p_snk = snk;
            if (cmp_p1 == cmp_p2) comp_bad++;
            if (cmp_p1 && first_p1 == 0) first_p1 = k;
            if (bus.valid && first_v == 0) begin
                first_v = k;
                code_v  = int'(bus.code);
                ch_v    = int'(bus.code_ch);
            end
            if (k == 278) begin
                v278 = int'(bus.valid);
                b278 = int'(busy);
            end
        end
        check({tag, " valid_cycle"}, first_v, 277);
        check({tag, " code"}, code_v, v.exp_code);
        check({tag, " code_ch"}, ch_v, int'(v.ch));
        check({tag, " preChrg_cycles"}, pre_n, 11);
        check({tag, " PII2_cycles"}, dio_n, 1);
        check({tag, " PI2_cycles"}, pi2_n, 263);
        check({tag, " PA_cycles"}, pa_n, 1);
        check({tag, " ch_en_bad"}, en_bad, 0);
        check({tag, " src_n_toggles"}, src_t, v.exp_src);
        check({tag, " snk_toggles"}, snk_t, v.exp_snk);
        check({tag, " chop_cycle"}, first_p1, 149);
        check({tag, " chop_not_compl"}, comp_bad, 0);
        check({tag, " valid_after_accept"}, v278, 0);
        check({tag, " busy_after_run"}, b278, 0);
    endtask

    initial begin
        vecs[0] = '{0, 1'b1, 0, 0, 263};
        vecs[1] = '{1, 1'b0, 255, 263, 0};
        vecs[2] = '{2, 1'b1, 128, 128, 135};
        vecs[3] = '{3, 1'b0, 0, 7, 256};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.cont   = 1'b0;
        bus.ch_sel = '0;
        bus.ready  = 1'b0;
        cmp        = 1'b0;
        repeat (3) tick();
        check("reset_zero_outs", int'(zero_outs), 0);
        check("reset_cmp_p2", int'(cmp_p2), 1);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++)
            run_single(vecs[i], $sformatf("vec%0d", i));

        // Continuous round-robin with ready=1; cont dropped during the third run.
        begin
            int nres = 0, gap = 0, b830 = -1;
            int chs[3];
            int rk[3];
            bus.ready = 1'b1;
            cmp       = 1'b0;
            tick();
            bus.cont = 1'b1;
            for (int k = 2; k <= 840; k++) begin
                tick();
                if (k == 600) bus.cont = 1'b0;
                if (k <= 829 && !busy) gap++;
                if (bus.valid) begin
                    if (nres < 3) begin
                        chs[nres] = int'(bus.code_ch);
                        rk[nres]  = k;
                    end
                    nres++;
                end
                if (k == 830) b830 = int'(busy);
            end
            check("cont_results", nres, 3);
            check("cont_ch0", chs[0], 0);
            check("cont_ch1", chs[1], 1);
            check("cont_ch2", chs[2], 0);
            check("cont_t1", rk[1], 553);
            check("cont_t2", rk[2], 829);
            check("cont_idle_gap", gap, 0);
            check("cont_idle_after", b830, 0);
            check("cont_idle_end", int'(busy), 0);
        end

        // Unread results: accept coinciding with a new result, then an overwrite.
        begin
            bus.ready = 1'b0;
            cmp       = 1'b0;
            tick();
            bus.cont = 1'b1;
            for (int k = 2; k <= 840; k++) begin
                tick();
                bus.ready = (k == 552) || (k == 835);
                if (k == 600) bus.cont = 1'b0;
                if (k == 400) begin
                    check("hold_valid", int'(bus.valid), 1);
                    check("hold_ch", int'(bus.code_ch), 0);
                    check("hold_ovf", int'(bus.ovf), 0);
                end
                if (k == 553) begin
                    check("acc_new_valid", int'(bus.valid), 1);
                    check("acc_new_ch", int'(bus.code_ch), 1);
                    check("acc_new_ovf", int'(bus.ovf), 0);
                end
                if (k == 829) begin
                    check("ovw_valid", int'(bus.valid), 1);
                    check("ovw_ch", int'(bus.code_ch), 0);
                    check("ovw_ovf", int'(bus.ovf), 1);
                end
                if (k == 836) begin
                    check("ovw_cleared_valid", int'(bus.valid), 0);
                    check("ovw_sticky_ovf", int'(bus.ovf), 1);
                end
            end
        end

        // Reset in the middle of CONVERT, then a full run.
        begin
            bus.ready = 1'b0;
            tick();
            bus.start  = 1'b1;
            bus.ch_sel = 1'b1;
            cmp        = 1'b1;
            for (int k = 2; k <= 101; k++) begin
                tick();
                bus.start = 1'b0;
                if (k == 100) begin
                    check("pre_reset_PI2", int'(PI2), 1);
                    reset = 1'b1;
                end
                if (k == 101) begin
                    check("midrst_zero_outs", int'(zero_outs), 0);
                    check("midrst_cmp_p2", int'(cmp_p2), 1);
                    reset = 1'b0;
                end
            end
            run_single('{0, 1'b0, 0, 0, 263}, "after_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
